// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory request port between the instruction fetch requester (IF)
// and the data requester (MEM stage). At most one request is issued per cycle.
// The data port normally has priority. A saturating counter tracks consecutive
// data grants while IF waits and forces an IF grant once it reaches STARVE_MAX.
// Read responses return a fixed MEM_LAT cycles after issue. A tag shift register
// tracks each response's owner, so the response is steered to the port that
// issued it.
//
// Ports:
//   CLK, RESET         clock; synchronous active-high reset
//   if_req/if_addr     fetch request and word address (held until if_gnt)
//   if_flush           drop every in-flight fetch response
//   if_gnt             fetch issued this cycle
//   if_stall           fetch pending but not granted
//   if_rvalid/if_rdata fetch response
//   d_req/d_we/d_addr/d_wdata/d_size/d_sign
//                      data request (held until d_gnt)
//   d_gnt              data request issued this cycle
//   d_rvalid/d_rdata   load response (stores return nothing)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_size/mem_sign
//                      memory request port
//   mem_rdata          memory read data, valid MEM_LAT cycles after mem_en
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]         cnt;
  logic               starve;
  logic [MEM_LAT-1:0] pipe_v;
  logic [MEM_LAT-1:0] pipe_owner;
  logic [MEM_LAT-1:0] live_v;
  logic               out_v;
  logic               out_owner;

  // Arbitration and request mux. The data port normally wins. Once the
  // starvation count is reached while both ports request, IF gets the slot.
  // Everything is forced to zero while RESET is high.
  always_comb begin
    starve    = if_req & d_req & (cnt >= STARVE_LIM);
    d_gnt     = ~RESET & d_req & ~starve;
    if_gnt    = ~RESET & if_req & (~d_req | starve);
    if_stall  = ~RESET & if_req & ~if_gnt;
    mem_en    = if_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_size  = 2'b00;
    mem_sign  = 1'b0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_size  = d_size;
      mem_sign  = d_sign;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
      mem_size  = 2'b10;
    end
  end

  // A flush kills every fetch-owned entry, including the one at the pipe
  // output this cycle. Entries written this cycle (the new fetch) are
  // unaffected because they are only written at the clock edge.
  always_comb begin
    live_v    = pipe_v & ~({MEM_LAT{if_flush}} & ~pipe_owner);
    out_v     = ~RESET & live_v[MEM_LAT-1];
    out_owner = pipe_owner[MEM_LAT-1];
    if_rvalid = out_v & ~out_owner;
    d_rvalid  = out_v & out_owner;
    if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    d_rdata   = d_rvalid  ? mem_rdata : 32'd0;
  end

  // Starvation counter and tag pipe. A store occupies a slot with v=0, so
  // response timing stays a fixed MEM_LAT cycles for every issued request.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt        <= 4'd0;
      pipe_v     <= '0;
      pipe_owner <= '0;
    end else begin
      if (if_gnt | ~if_req)
        cnt <= 4'd0;
      else if (d_gnt && cnt != 4'hF)
        cnt <= cnt + 4'd1;
      pipe_v[0]     <= if_gnt | (d_gnt & ~d_we);
      pipe_owner[0] <= d_gnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i]     <= live_v[i-1];
        pipe_owner[i] <= pipe_owner[i-1];
      end
    end
  end

endmodule
